// File: rtl/vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl
//   Raster sequencer for 640x480@60 VGA on the ~25.3 MHz pixel clock.
//   Free-running horizontal/vertical scan counters issue fetch coordinates to
//   the playfield renderer LOOKAHEAD cycles ahead of the beam. The renderer's
//   colour comes back LOOKAHEAD cycles later and is registered together with
//   the equally delayed sync/blank terms, so every DAC-side output describes
//   the counter state of LOOKAHEAD+1 cycles earlier.
//
// Ports
//   clock_in     in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   fetch_x/y    out  10-bit coordinate requested from the renderer (= counters)
//   fetch_valid  out  fetch coordinate lies in the visible area
//   pixel_rgb    in   renderer colour {R,G,B} for the fetch LOOKAHEAD cycles ago
//   vga_rgb      out  registered colour, forced to zero while blanked
//   vga_hsync    out  horizontal sync, active low
//   vga_vsync    out  vertical sync, active low
//   vga_de       out  display enable, aligned with vga_rgb
//   frame_tick   out  one-cycle pulse at the start of vertical blanking
// -----------------------------------------------------------------------------
module vga_scan_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned LOOKAHEAD = 2,
  parameter int unsigned RGB_W     = 3
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  output logic [9:0]           fetch_x,
  output logic [9:0]           fetch_y,
  output logic                 fetch_valid,
  input  logic [3*RGB_W-1:0]   pixel_rgb,
  output logic [3*RGB_W-1:0]   vga_rgb,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_de,
  output logic                 frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Boundary constants; comparisons are done one bit wider than the counters
  // so a sync region ending exactly at a total of 1024 still compares correctly.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  // Scan counters
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Delay lines for the raw timing terms (index 0 = newest)
  logic [LOOKAHEAD-1:0] valid_dly_q, valid_dly_d;
  logic [LOOKAHEAD-1:0] hs_dly_q,    hs_dly_d;
  logic [LOOKAHEAD-1:0] vs_dly_q,    vs_dly_d;

  // Output register
  logic [3*RGB_W-1:0] vga_rgb_q,    vga_rgb_d;
  logic               vga_hsync_q,  vga_hsync_d;
  logic               vga_vsync_q,  vga_vsync_d;
  logic               vga_de_q,     vga_de_d;
  logic               frame_tick_q, frame_tick_d;

  // Raw (undelayed) timing terms
  logic [10:0] h_ext, v_ext;
  logic        valid_raw;
  logic        hs_raw;
  logic        vs_raw;

  assign h_ext = {1'b0, h_cnt_q};
  assign v_ext = {1'b0, v_cnt_q};

  // ---------------------------------------------------------------------------
  // Counter next state: h wraps every line, v advances only on the h wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_ext == H_LAST) begin
      h_cnt_d = '0;
      if (v_ext == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch interface and raw timing terms
  // ---------------------------------------------------------------------------
  assign fetch_x     = h_cnt_q;
  assign fetch_y     = v_cnt_q;
  assign valid_raw   = (h_ext < H_VIS) && (v_ext < V_VIS);
  assign fetch_valid = valid_raw;
  assign hs_raw      = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_raw      = (v_ext >= VS_START) && (v_ext < VS_END);

  // ---------------------------------------------------------------------------
  // Delay lines: written as a loop so LOOKAHEAD=1 needs no special case.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_dly_d    = valid_dly_q;
    hs_dly_d       = hs_dly_q;
    vs_dly_d       = vs_dly_q;
    valid_dly_d[0] = valid_raw;
    hs_dly_d[0]    = hs_raw;
    vs_dly_d[0]    = vs_raw;
    for (int unsigned i = 1; i < LOOKAHEAD; i++) begin
      valid_dly_d[i] = valid_dly_q[i-1];
      hs_dly_d[i]    = hs_dly_q[i-1];
      vs_dly_d[i]    = vs_dly_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Output register inputs. pixel_rgb is only trusted when the delayed valid
  // says the matching fetch was visible; otherwise the DAC sees black.
  // ---------------------------------------------------------------------------
  always_comb begin
    vga_de_d     = valid_dly_q[LOOKAHEAD-1];
    vga_hsync_d  = ~hs_dly_q[LOOKAHEAD-1];
    vga_vsync_d  = ~vs_dly_q[LOOKAHEAD-1];
    vga_rgb_d    = valid_dly_q[LOOKAHEAD-1] ? pixel_rgb : '0;
    // Start of vertical blanking: first pixel of the first invisible line.
    frame_tick_d = (h_ext == 11'd0) && (v_ext == V_VIS);
  end

  // ---------------------------------------------------------------------------
  // State. Reset leaves the delay lines inactive so nothing partial emerges
  // after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      valid_dly_q  <= '0;
      hs_dly_q     <= '0;
      vs_dly_q     <= '0;
      vga_rgb_q    <= '0;
      vga_hsync_q  <= 1'b1;
      vga_vsync_q  <= 1'b1;
      vga_de_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      valid_dly_q  <= valid_dly_d;
      hs_dly_q     <= hs_dly_d;
      vs_dly_q     <= vs_dly_d;
      vga_rgb_q    <= vga_rgb_d;
      vga_hsync_q  <= vga_hsync_d;
      vga_vsync_q  <= vga_vsync_d;
      vga_de_q     <= vga_de_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga_rgb    = vga_rgb_q;
  assign vga_hsync  = vga_hsync_q;
  assign vga_vsync  = vga_vsync_q;
  assign vga_de     = vga_de_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_ctrl
//   Scoreboard bench for vga_scan_ctrl. Horizontal timing is the real 800-pixel
//   line; the vertical extent is shortened so whole frames fit a short run.
//   A stimulus/model process derives the expected outputs of each cycle from
//   the number of cycles since reset release, pushes them into a queue, and a
//   monitor pops and compares them mid-cycle. The monitor also measures sync
//   widths, frame_tick spacing and the first display-enable after release.
// -----------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  localparam int unsigned HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VV = 16,  VF = 3,  VS = 2,  VB = 4;
  localparam int unsigned LA = 2;
  localparam int unsigned RGB_W = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic                clock_in = 1'b0;
  logic                reset_n  = 1'b0;
  logic [9:0]          fetch_x, fetch_y;
  logic                fetch_valid;
  logic [3*RGB_W-1:0]  pixel_rgb;
  logic [3*RGB_W-1:0]  vga_rgb;
  logic                vga_hsync, vga_vsync, vga_de, frame_tick;

  vga_scan_ctrl #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .LOOKAHEAD (LA), .RGB_W (RGB_W)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .fetch_valid (fetch_valid),
    .pixel_rgb   (pixel_rgb),
    .vga_rgb     (vga_rgb),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_de      (vga_de),
    .frame_tick  (frame_tick)
  );

  always #5 clock_in = ~clock_in;

  // Renderer: two-cycle latency; junk (often all ones) for invisible fetches.
  logic [8:0] rend_q1 = '0, rend_q2 = '0;
  always @(posedge clock_in) begin
    if (fetch_valid)
      rend_q1 <= {fetch_x[2:0], fetch_y[2:0], 3'b101};
    else
      rend_q1 <= ($urandom_range(0, 1) == 1) ? 9'h1FF : 9'($urandom);
    rend_q2 <= rend_q1;
  end
  assign pixel_rgb = rend_q2;

  typedef struct packed {
    logic [9:0] fx;
    logic [9:0] fy;
    logic       fv;
    logic       de;
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
    logic       tick;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned c = 0;  // cycles since reset release (0 = cycle of release)

  function automatic exp_t reset_exp();
    exp_t e;
    e.fx = '0; e.fy = '0; e.fv = 1'b1;
    e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = '0; e.tick = 1'b0;
    return e;
  endfunction

  // Expected outputs for cycle cc after release, from raster arithmetic.
  function automatic exp_t model(input int unsigned cc);
    exp_t        e;
    int unsigned h, v, k;
    e = reset_exp();
    h = cc % HT;
    v = (cc / HT) % VT;
    e.fx = 10'(h);
    e.fy = 10'(v);
    e.fv = (h < HV) && (v < VV);
    if (cc >= LA + 1) begin
      k = cc - LA - 1;
      h = k % HT;
      v = (k / HT) % VT;
      e.de  = (h < HV) && (v < VV);
      e.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      e.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      e.rgb = e.de ? {3'(h % 8), 3'(v % 8), 3'b101} : 9'h000;
    end
    if (cc >= 1) begin
      k = cc - 1;
      e.tick = ((k % HT) == 0) && (((k / HT) % VT) == VV);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  exp_t        mon_e;
  int unsigned mcyc = 0, last_tick = 0, rel = 0, hrun = 0, vrun = 0;
  bit          have_tick = 0, seen_de = 0;

  initial begin
    forever begin
      @(negedge clock_in);
      #2;
      mcyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("fetch_x",     32'(fetch_x),     32'(mon_e.fx));
        chk("fetch_y",     32'(fetch_y),     32'(mon_e.fy));
        chk("fetch_valid", 32'(fetch_valid), 32'(mon_e.fv));
        chk("vga_de",      32'(vga_de),      32'(mon_e.de));
        chk("vga_hsync",   32'(vga_hsync),   32'(mon_e.hs));
        chk("vga_vsync",   32'(vga_vsync),   32'(mon_e.vs));
        chk("vga_rgb",     32'(vga_rgb),     32'(mon_e.rgb));
        chk("frame_tick",  32'(frame_tick),  32'(mon_e.tick));
      end
      if (!reset_n) begin
        hrun = 0; vrun = 0; rel = 0;
        have_tick = 0; seen_de = 0;
      end else begin
        if (vga_de && !seen_de) begin
          chk("de_first_rise", rel, LA + 1);
          seen_de = 1;
        end
        rel++;
        if (frame_tick) begin
          if (have_tick) chk("tick_period", mcyc - last_tick, FRAME);
          last_tick = mcyc;
          have_tick = 1;
        end
        if (!vga_hsync) hrun++;
        else begin
          if (hrun > 0) chk("hsync_width", hrun, HS);
          hrun = 0;
        end
        if (!vga_vsync) vrun++;
        else begin
          if (vrun > 0) chk("vsync_width", vrun, VS * HT);
          vrun = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus and model
  // ---------------------------------------------------------------------------
  task automatic run_to(input int unsigned tgt);
    while (c < tgt) begin
      @(negedge clock_in);
      c++;
      exp_q.push_back(model(c));
    end
  endtask

  // Assert reset mid-cycle, hold through n_edges rising edges, release mid-cycle.
  task automatic do_reset(input int unsigned n_edges);
    @(negedge clock_in);
    reset_n = 1'b0;
    exp_q.push_back(reset_exp());
    repeat (n_edges - 1) begin
      @(negedge clock_in);
      exp_q.push_back(reset_exp());
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    c = 0;
    exp_q.push_back(model(0));
  endtask

  initial begin
    int unsigned tgt;
    reset_n = 1'b0;
    repeat (5) begin
      @(negedge clock_in);
      exp_q.push_back(reset_exp());
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    c = 0;
    exp_q.push_back(model(0));

    // Two full frames (two frame_ticks, frame wrap), then stop at (300,10).
    run_to(2 * FRAME + 10 * HT + 300 - 1);
    do_reset(1);
    run_to(3 * HT);

    // Reset at a random point with a random hold length.
    tgt = $urandom_range(HT, 6 * HT);
    run_to(tgt - 1);
    do_reset($urandom_range(1, 3));
    run_to(2 * HT + 10);

    @(negedge clock_in);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster sequencer for the 640x480@60 VGA output, clocked by the ~25.3 MHz pixel clock from the VGA PLL. Maintains horizontal and vertical scan counters and issues pixel-fetch coordinates to the playfield renderer ahead of the beam. Realigns the renderer's returned colour with registered HSYNC/VSYNC/blanking, and pulses a once-per-frame tick for the game logic.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `LOOKAHEAD`, 2, renderer latency in cycles (1..4)
- `RGB_W`, 3, bits per colour channel
- `clock_in`  in  1  pixel clock (PLL global output)
- `reset_n`  in  1  asynchronous active-low reset
- `fetch_x`  out  10  column being requested from the renderer
- `fetch_y`  out  10  row being requested from the renderer
- `fetch_valid`  out  1  fetch coordinates lie in the visible area
- `pixel_rgb`  in  3*RGB_W  renderer colour for the fetch issued LOOKAHEAD cycles earlier, {R,G,B}
- `vga_rgb`  out  3*RGB_W  registered colour to the DAC; zero when blanked
- `vga_hsync`  out  1  horizontal sync, active low
- `vga_vsync`  out  1  vertical sync, active low
- `vga_de`  out  1  display-enable, aligned with `vga_rgb`
- `frame_tick`  out  1  one-cycle pulse at the start of vertical blanking

## Operation
- H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525). Both counters are 10 bits wide. Widths sized for totals ≤ 1024.
- `h_cnt` increments every cycle and wraps H_TOTAL-1 -> 0.
- `v_cnt` increments only when `h_cnt` wraps, and wraps V_TOTAL-1 -> 0. At h=799, v=524 both counters go to 0 in the same cycle.
- `fetch_x`/`fetch_y` are combinational copies of `h_cnt`/`v_cnt`. `fetch_valid` = (h < H_VISIBLE) && (v < V_VISIBLE).
- Raw sync terms:
  - hs_raw is active when H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw is active when V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Pipeline: `fetch_valid`, hs_raw and vs_raw each pass through a LOOKAHEAD-deep shift register. One final output register then captures:
  - `vga_de` ← delayed valid
  - `vga_hsync` ← ~delayed hs
  - `vga_vsync` ← ~delayed vs
  - `vga_rgb` ← delayed valid ? `pixel_rgb` : 0
- `frame_tick` is registered. It is 1 for exactly one cycle, the cycle after the counter state (h=0, v=V_VISIBLE).
- Not modelled: no stall input and no PLL-lock input. The counter free-runs whenever `reset_n` is high.

## Timing
- Reset (asynchronous assert; deassert sampled on the `clock_in` rising edge):
  - counters = 0; all delay stages = inactive (valid 0, hs/vs 0)
  - `vga_hsync`=1, `vga_vsync`=1, `vga_de`=0, `vga_rgb`=0, `frame_tick`=0
  - `fetch_x`=`fetch_y`=0 and `fetch_valid`=1 while in reset
- Alignment: outputs in cycle t describe the counter state of cycle t-LOOKAHEAD-1.
  - First `vga_de`=1 after reset release is LOOKAHEAD+1 cycles after the first edge with `reset_n` high.
- `pixel_rgb` is sampled only at the output register. Its value is don't-care when the delayed valid is 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). The scan restarts at (0,0). No partial pulses may be emitted after release; the pipeline holds only inactive values.
- Periods:
  - line = H_TOTAL cycles; `vga_hsync` low for H_SYNC cycles per line
  - frame = H_TOTAL*V_TOTAL = 420000 cycles
  - `vga_vsync` low for V_SYNC*H_TOTAL = 1600 cycles, starting on the same cycle hsync would begin a line at h=0
  - `frame_tick` period is exactly 420000 cycles

## Test plan
- **Reset and first line.** Hold `reset_n` low for 5 cycles, then release.
  - During reset: hsync=1, vsync=1, de=0, rgb=0.
  - `vga_de` rises at cycle 3 after release (LOOKAHEAD=2) and stays high for 640 cycles.
- **Line timing.** Over one line, `vga_hsync` falls 656+3 cycles after the line's h=0 and stays low for exactly 96 cycles. The line period is 800 cycles.
- **Frame timing.** Measure two consecutive `frame_tick` pulses: they are 420000 cycles apart. `vga_vsync` is low for 1600 cycles, beginning at counter state (0,490) + 3 cycles.
- **Colour alignment.** Renderer model returns `pixel_rgb` = {fetch_x[2:0], fetch_y[2:0], 3'b101}, delayed 2 cycles.
  - At every `vga_de`=1 cycle, `vga_rgb` matches the expected colour for the pixel position.
  - `vga_rgb`=0 whenever `vga_de`=0, even when the renderer drives 9'h1FF.
- **Wrap corner.** Check the state (799,524) → (0,0) transition: `fetch_valid` goes 0→1 and `frame_tick` does not fire. `frame_tick` fires once, after (0,480).
- **Reset mid-frame.** Assert `reset_n` low at counter (300,200) for 1 cycle.
  - Outputs go to reset values without waiting for a clock edge.
  - After release the scan restarts at (0,0) with no spurious sync pulse during the first 3 cycles.
